// File: rtl/kick_timer.sv
// kick_timer: restartable one-shot / auto-reload event timer with period counter.
// Optional prescaler enabled by defining KICK_PRESCALE_EN.
module kick_timer #(
    parameter int WIDTH         = 16,
    parameter int DEFAULT_LIMIT = 43840,
    parameter int PRESCALE      = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             en,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wraps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_L = WIDTH'(DEFAULT_LIMIT);

    // Parameter sanity: a zero or oversized default limit breaks the terminal compare.
    if (DEFAULT_LIMIT < 1 || DEFAULT_LIMIT >= (2 ** WIDTH)) begin : g_bad_limit
        $error("kick_timer: DEFAULT_LIMIT must be in 1..2**WIDTH-1");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("kick_timer: PRESCALE must be >= 2");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] lim_d;
    logic             per_q;
    logic             per_d;
    logic [7:0]       wraps_q;
    logic [7:0]       wraps_d;
    logic [7:0]       wraps_inc;
    logic             done_q;
    logic             done_d;
    logic             busy_q;
    logic             busy_d;
    logic             tick;
    logic             last;

`ifdef KICK_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = (state_q == RUN) && en && (pre_q == PRE_TOP);

    // Prescaler: counts enabled RUN cycles, wraps on each tick.
    always_comb begin
        pre_d = pre_q;
        if (abort || go) begin
            pre_d = '0;
        end else if (state_q == RUN && en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = (state_q == RUN) && en;
`endif

    // lim_q is never zero, so L-1 cannot underflow.
    assign last      = (count_q == lim_q - 1'b1);
    assign wraps_inc = (wraps_q == 8'hFF) ? 8'hFF : wraps_q + 8'd1;

    // Next-state and datapath: abort beats go beats tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wraps_d = wraps_q;
        lim_d   = lim_q;
        per_d   = per_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (go) begin
            state_d = RUN;
            count_d = '0;
            wraps_d = 8'd0;
            lim_d   = (limit == '0) ? DEF_L : limit;
            per_d   = periodic;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (tick) begin
                        if (last) begin
                            done_d = 1'b1;
                            if (per_q) begin
                                count_d = '0;
                                wraps_d = wraps_inc;
                            end else begin
                                count_d = lim_q;
                                wraps_d = 8'd1;
                                state_d = HALT;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= '0;
            wraps_q <= 8'd0;
            lim_q   <= DEF_L;
            per_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wraps_q <= wraps_d;
            lim_q   <= lim_d;
            per_q   <= per_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wraps = wraps_q;

endmodule

// File: tb/tb_kick_timer.sv
// tb_kick_timer: directed stimulus with a queued scoreboard for kick_timer.
// Expected outputs are pushed per cycle and checked by an independent monitor.
module tb_kick_timer;

    logic        clk;
    logic        resetn;
    logic        go;
    logic        en;
    logic        abort;
    logic [15:0] limit;
    logic        periodic;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [7:0]  wraps;

    typedef struct {
        string       tag;
        logic [15:0] c;
        logic        b;
        logic        d;
        logic [7:0]  w;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    kick_timer #(
        .WIDTH(16),
        .DEFAULT_LIMIT(43840),
        .PRESCALE(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .go(go),
        .en(en),
        .abort(abort),
        .limit(limit),
        .periodic(periodic),
        .count(count),
        .busy(busy),
        .done(done),
        .wraps(wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            n_checks++;
            if (count !== cur.c || busy !== cur.b ||
                done !== cur.d || wraps !== cur.w) begin
                n_fail++;
                $display("FAIL %s: got c=%0d b=%0b d=%0b w=%0d want c=%0d b=%0b d=%0b w=%0d",
                         cur.tag, count, busy, done, wraps,
                         cur.c, cur.b, cur.d, cur.w);
            end
        end
    end

    // One clock: drive inputs, queue the outputs expected after the edge.
    task automatic step(input string tag,
                        input logic rn, input logic g, input logic a,
                        input logic e, input logic [15:0] lim,
                        input logic p,
                        input logic [15:0] ec, input logic eb,
                        input logic ed, input logic [7:0] ew);
        exp_t x;
        resetn   = rn;
        go       = g;
        abort    = a;
        en       = e;
        limit    = lim;
        periodic = p;
        x.tag = tag;
        x.c   = ec;
        x.b   = eb;
        x.d   = ed;
        x.w   = ew;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; go = 1'b0; abort = 1'b0;
        en = 1'b0; limit = 16'd0; periodic = 1'b0;
        #1;

        // Reset held with go asserted
        step("rst0", 0, 1, 0, 1, 16'd5, 0, 0, 0, 0, 0);
        step("rst1", 0, 1, 0, 1, 16'd5, 0, 0, 0, 0, 0);
        step("idle", 1, 0, 0, 1, 16'd5, 0, 0, 0, 0, 0);

        // One-shot, L=5
        step("os_go", 1, 1, 0, 1, 16'd5, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++)
            step("os_run", 1, 0, 0, 1, 16'd0, 0, 16'(k),
                 k < 5, k == 5, (k == 5) ? 8'd1 : 8'd0);
        step("os_hold", 1, 0, 0, 1, 16'd0, 0, 5, 0, 0, 1);
        step("os_hold", 1, 0, 0, 1, 16'd0, 0, 5, 0, 0, 1);

        // Periodic, L=3, en low at edges N+4 and N+5
        step("per_go", 1, 1, 0, 1, 16'd3, 1, 0, 1, 0, 0);
        step("per1", 1, 0, 0, 1, 16'd0, 0, 1, 1, 0, 0);
        step("per2", 1, 0, 0, 1, 16'd0, 0, 2, 1, 0, 0);
        step("per3", 1, 0, 0, 1, 16'd0, 0, 0, 1, 1, 1);
        step("per4", 1, 0, 0, 0, 16'd0, 0, 0, 1, 0, 1);
        step("per5", 1, 0, 0, 0, 16'd0, 0, 0, 1, 0, 1);
        step("per6", 1, 0, 0, 1, 16'd0, 0, 1, 1, 0, 1);
        step("per7", 1, 0, 0, 1, 16'd0, 0, 2, 1, 0, 1);
        step("per8", 1, 0, 0, 1, 16'd0, 0, 0, 1, 1, 2);

        // Abort mid-run at count 2
        step("ab_go", 1, 1, 0, 1, 16'd5, 0, 0, 1, 0, 0);
        step("ab1", 1, 0, 0, 1, 16'd0, 0, 1, 1, 0, 0);
        step("ab2", 1, 0, 0, 1, 16'd0, 0, 2, 1, 0, 0);
        step("ab", 1, 0, 1, 1, 16'd0, 0, 2, 0, 0, 0);
        step("ab_idle", 1, 0, 0, 1, 16'd0, 0, 2, 0, 0, 0);

        // go together with abort: abort wins
        step("goab", 1, 1, 1, 1, 16'd4, 1, 2, 0, 0, 0);
        step("goab_idle", 1, 0, 0, 1, 16'd0, 0, 2, 0, 0, 0);

        // go on the terminal tick: go wins
        step("gt_go", 1, 1, 0, 1, 16'd2, 0, 0, 1, 0, 0);
        step("gt1", 1, 0, 0, 1, 16'd0, 0, 1, 1, 0, 0);
        step("gt_re", 1, 1, 0, 1, 16'd2, 0, 0, 1, 0, 0);
        step("gt_a", 1, 0, 0, 1, 16'd0, 0, 1, 1, 0, 0);
        step("gt_b", 1, 0, 0, 1, 16'd0, 0, 2, 0, 1, 1);

        // Periodic L=1: done every tick, wraps saturates
        step("sat_go", 1, 1, 0, 1, 16'd1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 300; k++)
            step("sat", 1, 0, 0, 1, 16'd0, 0, 0, 1, 1,
                 (k > 255) ? 8'd255 : 8'(k));
        step("sat_pause", 1, 0, 0, 0, 16'd0, 0, 0, 1, 0, 255);

        // Reset mid-run
        step("rr_go", 1, 1, 0, 1, 16'd5, 0, 0, 1, 0, 0);
        step("rr1", 1, 0, 0, 1, 16'd0, 0, 1, 1, 0, 0);
        step("rr_rst", 0, 0, 0, 1, 16'd0, 0, 0, 0, 0, 0);
        step("rr_idle", 1, 0, 0, 1, 16'd0, 0, 0, 0, 0, 0);

        // Prescaler check, L=2 one-shot
        step("ps_go", 1, 1, 0, 1, 16'd2, 0, 0, 1, 0, 0);
`ifdef KICK_PRESCALE_EN
        for (int k = 1; k <= 8; k++)
            step("ps", 1, 0, 0, 1, 16'd0, 0, 16'(k / 4),
                 k < 8, k == 8, (k == 8) ? 8'd1 : 8'd0);
`else
        for (int k = 1; k <= 2; k++)
            step("ps", 1, 0, 0, 1, 16'd0, 0, 16'(k),
                 k < 2, k == 2, (k == 2) ? 8'd1 : 8'd0);
`endif

        // limit 0 selects the default terminal value 43840
        step("l0_go", 1, 1, 0, 1, 16'd0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 43840; k++)
            step("l0", 1, 0, 0, 1, 16'd0, 0, 16'(k),
                 k < 43840, k == 43840,
                 (k == 43840) ? 8'd1 : 8'd0);
        step("l0_hold", 1, 0, 0, 1, 16'd0, 0, 16'd43840, 0, 0, 1);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kick_timer.md
# kick_timer

Parametrised, restartable event timer: the next generation of the fixed 16-bit kick counter. Counts qualified `en` ticks up to a terminal value latched at `go`, in one-shot or auto-reload mode. Provides `busy`, a one-cycle `done` pulse and a period counter. Sits between game-control FSMs and display/sound timers, which previously each hard-coded their own limit.

## Interface
- `WIDTH`, 16, counter width.
- `DEFAULT_LIMIT`, 43840, terminal value used when `limit` is 0 at `go`; must fit in `WIDTH`.
- `PRESCALE`, 4, ticks-per-count divider; used only with `KICK_PRESCALE_EN`; must be ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `go` in 1: start/restart; latches `limit` and `periodic`.
- `en` in 1: count enable; low pauses counting without losing state.
- `abort` in 1: stop and return to IDLE.
- `limit` in WIDTH: terminal count, sampled only on `go`; 0 selects `DEFAULT_LIMIT`.
- `periodic` in 1: sampled on `go`; 1 = auto-reload, 0 = one-shot.
- `count` out WIDTH: current count.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at terminal count.
- `wraps` out 8: completed periods since last `go`, saturating at 255.

## Operation
- States: IDLE (reset), RUN, HALT.
- Reset values: state IDLE, `count` 0, `busy` 0, `done` 0, `wraps` 0, latched limit `DEFAULT_LIMIT`, latched mode one-shot.
- Priority per edge: `resetn` low > `abort` > `go` > tick.
- `abort` (any state): state IDLE, `count` held, `done` 0, `wraps` held, prescaler cleared.
- `go` (any state, including RUN and HALT): `count` 0, `wraps` 0, `done` 0, latch limit (L) and mode, state RUN.
- tick = `en` (see Configuration); evaluated only in RUN. IDLE and HALT ignore `en`.
- One-shot, RUN, tick:
  - If `count` == L−1: `count` ← L, `done` ← 1, `wraps` ← 1, state HALT.
  - Otherwise: `count` +1.
- HALT: `count` held at L, `busy` 0, leaves only on `go`, `abort` or reset.
- Periodic, RUN, tick:
  - If `count` == L−1: `count` ← 0, `done` ← 1, `wraps` +1 (saturating).
  - Otherwise: `count` +1.
  - Runs forever, with a period of L ticks.
- Arithmetic is unsigned `WIDTH`-bit. `count` never exceeds L and never wraps through 2^WIDTH.
- L = 1:
  - One-shot: finishes on the first tick.
  - Periodic: `count` stays 0 and `done` pulses on every tick.
- `done` is 0 on every cycle other than the terminal-tick edge. `busy` is the registered state==RUN.

## Timing
- `go` sampled at edge N: after edge N, `busy`=1 and `count`=0. The first increment happens at edge N+1 if tick is high.
- One-shot with L and `en` held high, `go` at edge N: after edge N+L, `count`=L, `done`=1, `busy`=0. After edge N+L+1, `done`=0.
- Periodic with `en` held high, `go` at edge N: `done` is high after edges N+k·L, for k ≥ 1.
- `en` low for M cycles in RUN delays completion by exactly M cycles; `count` is frozen meanwhile.
- `go` and `abort` on the same edge: `abort` wins; the result is IDLE.
- `go` on the same edge as the terminal tick: `go` wins; no `done`, `count` 0.
- Reset mid-RUN: all outputs return to reset values after that edge.

## Configuration
- `KICK_PRESCALE_EN` defined:
  - An internal prescaler counts `en`-high cycles in RUN.
  - tick = `en` && prescaler == `PRESCALE`−1; the prescaler wraps to 0 on that tick.
  - The prescaler is cleared by reset, `go` and `abort`, and holds while `en` is low.
  - One-shot completion takes L·`PRESCALE` enabled cycles.
- `KICK_PRESCALE_EN` undefined: no prescaler logic; tick = `en`; `PRESCALE` ignored.

## Test plan
- Reset: `resetn`=0 for 2 cycles with `go`=1 -> `count`=0, `busy`=0, `done`=0, `wraps`=0.
- One-shot: `limit`=5, `periodic`=0, `go` at edge N, `en`=1 -> `count` 1..5 on edges N+1..N+5, `done` high only after N+5, `busy` 0 from N+5, `count` held at 5.
- Periodic with pause: `limit`=3, `periodic`=1, `en` low for cycles 4–5 -> `done` after edges N+3 and N+8, `wraps` = 1 then 2, `count` sequence 0,1,2,0,0,0,1,2,0.
- Limit 0 / saturation: `limit`=0 -> latched L=43840. `periodic` with `limit`=1 for 300 ticks -> `wraps` saturates at 255 while `done` keeps pulsing.
- Collisions: `go`+`abort` together -> IDLE. `go` on the terminal tick -> `count`=0, no `done`. `abort` mid-RUN at `count`=2 -> `count` held at 2, `busy`=0.
- `KICK_PRESCALE_EN`, `PRESCALE`=4, `limit`=2, one-shot -> `done` 8 enabled cycles after `go`. Without the macro, the same stimulus -> `done` after 2 cycles.
